bp_me_cache_dma_to_mem: RTL

// - Downstream of the L2 bsg_cache DMA port. Converts block-granular dma_pkt/dma_data streams into per-beat

---
 rtl/bp_me_cache_dma_to_mem_pkg.sv | 10 +
 rtl/bp_me_cache_dma_to_mem_fifo.sv | 50 +++++
 rtl/bp_me_cache_dma_to_mem.sv | 108 ++++++++++
 3 files changed

// File: rtl/bp_me_cache_dma_to_mem_pkg.sv
// bp_me_pkg: shared types for the cache-DMA to memory-beat converter
package bp_me_pkg;

    typedef enum logic [1:0] {
        e_ready,
        e_read,
        e_write
    } bp_me_dma_state_e;

endpackage

// File: rtl/bp_me_cache_dma_to_mem_fifo.sv
// bsg_fifo_1r1w_small: small one-read one-write fifo used as the read-response buffer
module bsg_fifo_1r1w_small #(
    parameter int width_p = 64,
    parameter int els_p   = 4
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic [width_p-1:0] data_i,
    input  logic               v_i,
    output logic               ready_o,
    output logic [width_p-1:0] data_o,
    output logic               v_o,
    input  logic               yumi_i
);

    localparam int ptr_w_lp = (els_p > 1) ? $clog2(els_p) : 1;
    localparam int cnt_w_lp = $clog2(els_p + 1);
    localparam logic [ptr_w_lp-1:0] last_lp = ptr_w_lp'(els_p - 1);

    logic [width_p-1:0]  mem_q [els_p];
    logic [ptr_w_lp-1:0] wptr_q, rptr_q;
    logic [cnt_w_lp-1:0] cnt_q;
    logic                enq, deq;

    // full blocks enqueue even if a dequeue happens in the same cycle
    assign ready_o = cnt_q != cnt_w_lp'(els_p);
    assign v_o     = cnt_q != '0;
    assign data_o  = mem_q[rptr_q];
    assign enq     = v_i & ready_o;
    assign deq     = yumi_i & v_o;

    // pointer and occupancy bookkeeping
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= enq ? ((wptr_q == last_lp) ? '0 : wptr_q + 1'b1) : wptr_q;
            rptr_q <= deq ? ((rptr_q == last_lp) ? '0 : rptr_q + 1'b1) : rptr_q;
            cnt_q  <= cnt_q + cnt_w_lp'(enq) - cnt_w_lp'(deq);
        end
    end

    // storage needs no reset; occupancy decides what is valid
    always_ff @(posedge clk_i) begin
        if (enq) mem_q[wptr_q] <= data_i;
    end

endmodule

// File: rtl/bp_me_cache_dma_to_mem.sv
// bp_me_cache_dma_to_mem: splits block DMA requests into per-beat memory read/write commands
module bp_me_cache_dma_to_mem
    import bp_me_pkg::*;
#(
    parameter int daddr_width_p        = 40,
    parameter int fill_width_p         = 64,
    parameter int block_size_in_fill_p = 8,
    parameter int resp_els_p           = 4
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic [daddr_width_p:0]   dma_pkt_i,
    input  logic                     dma_pkt_v_i,
    output logic                     dma_pkt_yumi_o,
    output logic [fill_width_p-1:0]  dma_data_o,
    output logic                     dma_data_v_o,
    input  logic                     dma_data_ready_and_i,
    input  logic [fill_width_p-1:0]  dma_data_i,
    input  logic                     dma_data_v_i,
    output logic                     dma_data_yumi_o,
    output logic                     mem_cmd_v_o,
    output logic                     mem_cmd_w_o,
    output logic [daddr_width_p-1:0] mem_cmd_addr_o,
    output logic [fill_width_p-1:0]  mem_cmd_data_o,
    input  logic                     mem_cmd_ready_and_i,
    input  logic [fill_width_p-1:0]  mem_resp_data_i,
    input  logic                     mem_resp_v_i,
    output logic                     mem_resp_ready_and_o
);

    localparam int fill_bytes_lp = fill_width_p / 8;
    localparam int byte_w_lp     = $clog2(fill_bytes_lp);
    localparam int cnt_w_lp      = $clog2(block_size_in_fill_p) + 1;
    localparam logic [cnt_w_lp-1:0] last_lp = cnt_w_lp'(block_size_in_fill_p - 1);
    localparam logic [cnt_w_lp-1:0] size_lp = cnt_w_lp'(block_size_in_fill_p);
    localparam logic [daddr_width_p-1:0] off_mask_lp = daddr_width_p'(fill_bytes_lp * block_size_in_fill_p - 1);

    bp_me_dma_state_e          state_q;
    logic [daddr_width_p-1:0]  base_q;
    logic [cnt_w_lp-1:0]       issue_q, ret_q;
    logic                      cmd_fire, fill_fire, rd_credit, buf_ready;

    // outstanding reads never exceed buffer space, so no response is ever refused for lack of room
    assign rd_credit = (issue_q < size_lp) && (32'(issue_q - ret_q) < 32'(resp_els_p));

    assign mem_cmd_v_o          = (state_q == e_write) ? dma_data_v_i : (state_q == e_read) & rd_credit;
    assign mem_cmd_w_o          = state_q == e_write;
    assign mem_cmd_addr_o       = base_q + (daddr_width_p'(issue_q) << byte_w_lp);
    assign mem_cmd_data_o       = dma_data_i;
    assign cmd_fire             = mem_cmd_v_o & mem_cmd_ready_and_i;
    assign dma_data_yumi_o      = (state_q == e_write) & cmd_fire;
    assign dma_pkt_yumi_o       = (state_q == e_ready) & dma_pkt_v_i & ~reset_i;
    assign fill_fire            = dma_data_v_o & dma_data_ready_and_i;
    assign mem_resp_ready_and_o = (state_q == e_read) & buf_ready;

    bsg_fifo_1r1w_small #(
        .width_p(fill_width_p),
        .els_p  (resp_els_p)
    ) resp_buf (
        .clk_i  (clk_i),
        .reset_i(reset_i),
        .data_i (mem_resp_data_i),
        .v_i    (mem_resp_v_i & mem_resp_ready_and_o),
        .ready_o(buf_ready),
        .data_o (dma_data_o),
        .v_o    (dma_data_v_o),
        .yumi_i (fill_fire)
    );

    // block sequencer: accept a packet, walk the beats, return to ready when the block is done
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= e_ready;
            issue_q <= '0;
            ret_q   <= '0;
        end else begin
            case (state_q)
                e_ready: if (dma_pkt_yumi_o) state_q <= dma_pkt_i[daddr_width_p] ? e_write : e_read;
                e_write: if (cmd_fire) begin
                    state_q <= (issue_q == last_lp) ? e_ready : e_write;
                    issue_q <= (issue_q == last_lp) ? '0 : issue_q + 1'b1;
                end
                e_read: begin
                    if (fill_fire && ret_q == last_lp) begin
                        state_q <= e_ready;
                        issue_q <= '0;
                        ret_q   <= '0;
                    end else begin
                        issue_q <= issue_q + cnt_w_lp'(cmd_fire);
                        ret_q   <= ret_q + cnt_w_lp'(fill_fire);
                    end
                end
                default: state_q <= e_ready;
            endcase
        end
    end

    // block-aligned base address captured with the packet
    always_ff @(posedge clk_i) begin
        if (dma_pkt_yumi_o) base_q <= dma_pkt_i[daddr_width_p-1:0] & ~off_mask_lp;
    end

    a_resp_only_in_read: assert property (@(posedge clk_i) disable iff (reset_i)
        mem_resp_v_i |-> state_q == e_read);
    a_evict_only_in_write: assert property (@(posedge clk_i) disable iff (reset_i)
        dma_data_yumi_o |-> state_q == e_write);

endmodule
